// File: rtl/rr_arbiter_8.sv
// Eight-requester round-robin arbiter with a registered one-hot grant,
// owner release via done/req drop, and a bounded hold time with timeout pulse.
module rr_arbiter_8 #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned HCW      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam int unsigned NREQ = 8;
  localparam int unsigned IW   = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [HCW-1:0]  hold_q, hold_d;
  logic [IW-1:0]   idx_d;
  logic            valid_d;
  logic            timeout_d;
  logic [NREQ-1:0] gnt_d;

  logic [2*NREQ-1:0] req_dbl_c;
  logic [NREQ-1:0]   req_rot_c;
  logic [IW-1:0]     win_off_c;
  logic [IW-1:0]     win_idx_c;
  logic              rel_done_c;
  logic              rel_drop_c;
  logic              rel_hold_c;
  logic              release_c;

  // Rotate so the pointer position lands at bit 0, then take the lowest set bit.
  assign req_dbl_c = {req, req};
  assign req_rot_c = NREQ'(req_dbl_c >> ptr_q);

  always_comb begin
    win_off_c = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_rot_c[i]) win_off_c = IW'(i);
    end
  end

  assign win_idx_c = ptr_q + win_off_c;

  // Release causes evaluated against the current owner.
  assign rel_done_c = done;
  assign rel_drop_c = ~req[gnt_idx];
  assign rel_hold_c = (hold_q == HCW'(MAX_HOLD - 1));
  assign release_c  = rel_done_c | rel_drop_c | rel_hold_c;

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      hold_q    <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      gnt       <= '0;
      timeout   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      gnt_idx   <= idx_d;
      gnt_valid <= valid_d;
      gnt       <= gnt_d;
      timeout   <= timeout_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    idx_d     = gnt_idx;
    valid_d   = gnt_valid;
    timeout_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (|req) begin
          idx_d   = win_idx_c;
          valid_d = 1'b1;
          hold_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (release_c) begin
          valid_d   = 1'b0;
          ptr_d     = gnt_idx + IW'(1);
          timeout_d = rel_hold_c & ~rel_done_c & ~rel_drop_c;
          state_d   = IDLE;
        end else begin
          hold_d = hold_q + HCW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // 3-to-8 decode of the next owner; zero whenever no grant is active.
  always_comb begin
    gnt_d = '0;
    if (valid_d) gnt_d[idx_d] = 1'b1;
  end

endmodule
